// File: rtl/lane_serial_eval.sv
// Change-driven per-lane evaluator: one shared squarer, one lane per cycle.
// Ports: i_clk, i_rst (sync, active-high), i_x/i_valid/o_ready in,
//        o_y/o_valid/i_ready out, o_dirty (lanes re-evaluated), o_busy.
// Option: LANE_SERIAL_EVAL_FORCEALL_EN re-evaluates every lane on every accept.
module lane_serial_eval #(
  parameter int N_LANE = 5,
  parameter int W      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_LANE*W-1:0]   i_x,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [N_LANE*W-1:0]   o_y,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [N_LANE-1:0]     o_dirty,
  output logic                  o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam int IW = (N_LANE > 1) ? $clog2(N_LANE) : 1;

  logic [1:0]            state_q, state_d;
  logic [N_LANE*W-1:0]   snap_q, snap_d;
  logic [N_LANE*W-1:0]   y_q, y_d;
  logic [N_LANE-1:0]     pend_q, pend_d;
  logic [N_LANE-1:0]     dirty_q, dirty_d;
  logic                  valid_q, valid_d;

  logic [N_LANE-1:0]     k_mask;
  logic [N_LANE-1:0]     sel_oh;
  logic [IW-1:0]         sel_idx;
  logic [W-1:0]          sel_val;
  logic [2*W-1:0]        sq;

`ifdef LANE_SERIAL_EVAL_FORCEALL_EN
  assign k_mask = '1;
`else
  logic primed_q, primed_d;

  // Until the first accept, the snapshot is meaningless: evaluate everything.
  always_comb begin
    k_mask = '1;
    if (primed_q) begin
      for (int i = 0; i < N_LANE; i++) begin
        k_mask[i] = (i_x[i*W +: W] != snap_q[i*W +: W]);
      end
    end
  end
`endif

  // Lowest-index pending lane.
  assign sel_oh = pend_q & (~pend_q + N_LANE'(1));

  always_comb begin
    sel_idx = '0;
    for (int i = N_LANE - 1; i >= 0; i--) begin
      if (pend_q[i]) sel_idx = IW'(i);
    end
  end

  assign sel_val = snap_q[sel_idx*W +: W];
  assign sq      = {{W{1'b0}}, sel_val} * {{W{1'b0}}, sel_val};

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    y_d     = y_q;
    pend_d  = pend_q;
    dirty_d = dirty_q;
    valid_d = valid_q;
`ifndef LANE_SERIAL_EVAL_FORCEALL_EN
    primed_d = primed_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          snap_d  = i_x;
          pend_d  = k_mask;
          dirty_d = k_mask;
`ifndef LANE_SERIAL_EVAL_FORCEALL_EN
          primed_d = 1'b1;
`endif
          if (|k_mask) begin
            state_d = S_EVAL;
          end else begin
            state_d = S_OUT;
            valid_d = 1'b1;
          end
        end
      end
      S_EVAL: begin
        y_d[sel_idx*W +: W] = sq[W-1:0];
        pend_d = pend_q & ~sel_oh;
        if (pend_d == '0) begin
          state_d = S_OUT;
          valid_d = 1'b1;
        end
      end
      S_OUT: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      y_q     <= '0;
      pend_q  <= '0;
      dirty_q <= '0;
      valid_q <= 1'b0;
`ifndef LANE_SERIAL_EVAL_FORCEALL_EN
      primed_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      y_q     <= y_d;
      pend_q  <= pend_d;
      dirty_q <= dirty_d;
      valid_q <= valid_d;
`ifndef LANE_SERIAL_EVAL_FORCEALL_EN
      primed_q <= primed_d;
`endif
    end
  end

  assign o_ready = (state_q == S_IDLE) && !i_rst;
  assign o_busy  = (state_q != S_IDLE);
  assign o_y     = y_q;
  assign o_valid = valid_q;
  assign o_dirty = dirty_q;

endmodule

// File: tb/tb_lane_serial_eval.sv
// Scoreboard bench for lane_serial_eval.
// Expected results come from a lane-level reference model in the bench.
module tb_lane_serial_eval;

  localparam int N = 5;
  localparam int W = 8;

  logic           clk = 0;
  logic           rst;
  logic [N*W-1:0] x;
  logic           vin;
  logic           rdy;
  logic [N*W-1:0] y;
  logic           vout;
  logic           rin;
  logic [N-1:0]   dirty;
  logic           busy;

  lane_serial_eval #(.N_LANE(N), .W(W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_x    (x),
    .i_valid(vin),
    .o_ready(rdy),
    .o_y    (y),
    .o_valid(vout),
    .i_ready(rin),
    .o_dirty(dirty),
    .o_busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*W-1:0] y;
    logic [N-1:0]   dirty;
    int             lat;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic [N*W-1:0] m_snap;
  logic [N*W-1:0] m_y;
  logic           m_primed;

  function automatic logic [N*W-1:0] pack(int a, int b, int c, int d, int e);
    logic [N*W-1:0] v;
    v = {e[W-1:0], d[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
    return v;
  endfunction

  function automatic exp_t model(logic [N*W-1:0] v);
    exp_t e;
    logic [N-1:0] m;
    logic [2*W-1:0] p;
    int k;
    k = 0;
    for (int i = 0; i < N; i++) begin
`ifdef LANE_SERIAL_EVAL_FORCEALL_EN
      m[i] = 1'b1;
`else
      m[i] = m_primed ? (v[i*W +: W] != m_snap[i*W +: W]) : 1'b1;
`endif
      if (m[i]) begin
        p = {{W{1'b0}}, v[i*W +: W]} * {{W{1'b0}}, v[i*W +: W]};
        m_y[i*W +: W] = p[W-1:0];
        k++;
      end
    end
    m_snap   = v;
    m_primed = 1'b1;
    e.y      = m_y;
    e.dirty  = m;
    e.lat    = 1 + k;
    return e;
  endfunction

  task automatic send(input logic [N*W-1:0] v);
    @(negedge clk);
    n_chk++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: o_ready=%b want 1", rdy);
    end
    x   = v;
    vin = 1'b1;
    q.push_back(model(v));
    @(posedge clk);
    #1 vin = 1'b0;
  endtask

  task automatic recv(input int hold);
    exp_t e;
    int cyc;
    logic [N*W-1:0] ys;
    cyc = 0;
    e = q.pop_front();
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (vout === 1'b1) break;
    end
    n_chk++;
    if (cyc != e.lat) begin
      n_fail++;
      $display("FAIL latency: got %0d want %0d", cyc, e.lat);
    end
    n_chk++;
    if (y !== e.y) begin
      n_fail++;
      $display("FAIL o_y: got %h want %h", y, e.y);
    end
    n_chk++;
    if (dirty !== e.dirty) begin
      n_fail++;
      $display("FAIL o_dirty: got %b want %b", dirty, e.dirty);
    end
    ys = y;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_chk++;
      if (vout !== 1'b1 || y !== ys || rdy !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold: v=%b y=%h r=%b b=%b want 1 %h 0 1",
                 vout, y, rdy, busy, ys);
      end
    end
    rin = 1'b1;
    @(negedge clk);
    rin = 1'b0;
    n_chk++;
    if (vout !== 1'b0 || busy !== 1'b0 || rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL release: v=%b b=%b r=%b want 0 0 1", vout, busy, rdy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (y !== '0 || vout !== 1'b0 || dirty !== '0 || busy !== 1'b0 || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: y=%h v=%b d=%b b=%b r=%b want 0 0 0 0 0",
               y, vout, dirty, busy, rdy);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: o_ready=%b want 1", rdy);
    end
  endtask

  task automatic test_first;
    send(pack(3, 4, 5, 6, 7));
    recv(0);
  endtask

  task automatic test_single_change;
    send(pack(3, 4, 16, 6, 7));
    recv(0);
  endtask

  task automatic test_no_change;
    send(pack(3, 4, 16, 6, 7));
    recv(0);
  endtask

  task automatic test_backpressure;
    send(pack(255, 1, 0, 128, 2));
    recv(4);
  endtask

  task automatic test_reset_mid_eval;
    logic [N*W-1:0] v;
    v = pack(10, 11, 12, 13, 14);
    send(v);
    void'(q.pop_back());
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if (rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready: o_ready=%b want 0", rdy);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    m_y      = '0;
    m_snap   = '0;
    m_primed = 1'b0;
    n_chk++;
    if (y !== '0 || vout !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: y=%h v=%b b=%b want 0 0 0", y, vout, busy);
    end
    send(v);
    recv(0);
  endtask

  task automatic test_repeat;
    send(pack(20, 21, 22, 23, 24));
    recv(0);
    send(pack(20, 21, 22, 23, 24));
    recv(0);
  endtask

  initial begin
    rst      = 1'b1;
    x        = '0;
    vin      = 1'b0;
    rin      = 1'b0;
    m_snap   = '0;
    m_y      = '0;
    m_primed = 1'b0;
    test_reset();
    test_first();
    test_single_change();
    test_no_change();
    test_backpressure();
    test_reset_mid_eval();
    test_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_serial_eval.md
Name: lane_serial_eval

Overview:
- Time-multiplexed, change-driven per-lane evaluator.
- Sits directly downstream of a packed multi-lane input vector (x) and produces the per-lane result vector (y).
- Replaces N parallel copies of a costly per-lane function with one shared compute unit.
- Only lanes whose value changed since the last accepted transaction are re-evaluated, one lane per cycle.
- Results are returned over a valid/ready handshake.

Parameters:
- N_LANE, 5, number of lanes (>=1).
- W, 8, bits per lane.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, synchronous, active-high.
- i_x  input  N_LANE*W  packed lanes; lane i = i_x[i*W +: W].
- i_valid  input  1  upstream offers i_x.
- o_ready  output  1  block can accept; combinational, high only in IDLE.
- o_y  output  N_LANE*W  packed results, registered.
- o_valid  output  1  o_y complete, registered.
- i_ready  input  1  downstream consumes o_y.
- o_dirty  output  N_LANE  lanes that differed in the last accepted transaction, registered.
- o_busy  output  1  high in EVAL or OUT.

Behaviour:
- Clock and reset: one clock (i_clk); reset (i_rst) is synchronous and active-high.
- Reset values:
  - o_y=0, o_valid=0, o_dirty=0, o_busy=0.
  - State=IDLE; snapshot=0; primed=0.
  - o_ready=0 while i_rst is high.
- Function: f(v) = (v*v)[W-1:0], unsigned, computed at full 2W width then truncated.
- IDLE:
  - o_ready=1.
  - Accept when i_valid && o_ready, at cycle t. On accept:
    - snapshot<=i_x.
    - Pending mask k_mask = primed ? (per-lane i_x != snapshot) : all ones.
    - o_dirty<=k_mask; primed<=1.
    - Next state is EVAL if k_mask!=0, else OUT.
- EVAL:
  - Each cycle select the lowest-index set bit j of the pending mask.
  - o_y lane j <= f(snapshot lane j); clear bit j.
  - When the last bit clears, next state is OUT.
  - Exactly one lane is written per cycle.
- OUT:
  - o_valid=1; hold o_y stable until i_ready.
  - On i_ready: o_valid<=0, next state IDLE. No new accept occurs in that same cycle.
- Latency:
  - o_valid first high at cycle t+1+k, where k = popcount(k_mask).
  - Minimum 1 (no change); maximum N_LANE+1 (first transaction or all lanes changed).
- Non-dirty lanes of o_y keep their previous results. These remain correct because their inputs are unchanged.
- i_x is ignored outside IDLE; upstream must hold it only until accepted.
- i_ready while o_valid=0 has no effect.
- Reset in any state (including mid-EVAL):
  - Returns to the reset values above, so the partially updated o_y is discarded.
  - primed=0, so the next transaction re-evaluates all lanes.
- o_busy = (state != IDLE).

Optional Feature:
- Macro: LANE_SERIAL_EVAL_FORCEALL_EN.
- Defined: change detection is bypassed.
  - k_mask is all ones on every accept.
  - Latency is fixed at N_LANE+1.
  - o_dirty reports all ones.
  - The snapshot comparator is not built.
- Undefined: change-driven behaviour as specified above.

Test Plan:
- Reset, then accept i_x lanes[0..4]=[3,4,5,6,7] -> o_dirty=5'b11111; o_valid at t+6; o_y=[9,16,25,36,49].
- Next, accept [3,4,16,6,7] -> o_dirty=5'b00100; o_valid at t+2; o_y=[9,16,0,36,49]; lane 2 wraps (256 mod 256).
- Re-send identical [3,4,16,6,7] -> o_dirty=0; o_valid at t+1; o_y unchanged.
- Lanes [255,1,0,128,2], all changed -> o_valid at t+6; o_y=[1,1,0,0,4]. Then hold i_ready=0 for 4 cycles -> o_valid=1, o_y stable, o_ready=0, o_busy=1 throughout; release -> IDLE next cycle.
- Assert i_rst after 2 EVAL cycles -> next cycle o_y=0, o_valid=0, o_busy=0. Re-send the prior vector -> o_dirty=5'b11111 and latency 6.
- Build with LANE_SERIAL_EVAL_FORCEALL_EN, send the same vector twice -> both transactions have latency 6 and o_dirty=5'b11111.
